// File: rtl/countdown_loader.sv
// countdown_loader: queues countdown requests in a small FIFO and sequences the 4-bit counter stage.
// Optional abort/flush port is enabled by defining COUNTDOWN_LOADER_ABORT_EN.
module countdown_loader #(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
`ifdef COUNTDOWN_LOADER_ABORT_EN
    input  logic       abort,
`endif
    input  logic       req_valid,
    input  logic [3:0] req_value,
    output logic       req_ready,
    output logic       latch,
    output logic [3:0] load_value,
    output logic       dec,
    input  logic       zero,
    output logic       busy,
    output logic       done
);

    localparam int unsigned VAL_W = 4;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [VAL_W-1:0]  mem_q [FIFO_DEPTH];
    logic [VAL_W-1:0]  mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic              latch_q, latch_d;
    logic [VAL_W-1:0]  load_value_q, load_value_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic              dec_c;
    logic [VAL_W-1:0]  head_c;

    // FIFO status from pointers; the extra wrap bit separates full from empty
    always_comb begin
        full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_c = (wr_ptr_q == rd_ptr_q);
        push_c  = req_valid && !full_c;
        pop_c   = (state_q == S_LOAD) && !empty_c;
        head_c  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next state, FIFO update, prescaler and registered outputs
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        pcnt_d       = pcnt_q;
        load_value_d = load_value_q;
        latch_d      = 1'b0;
        dec_c        = 1'b0;

        if (push_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = req_value;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    state_d      = S_LOAD;
                    latch_d      = 1'b1;
                    load_value_d = head_c;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                pcnt_d  = '0;
            end
            S_RUN: begin
                if (zero) begin
                    state_d = S_DONE;
                end else begin
                    dec_c  = (pcnt_q == CNT_LAST);
                    pcnt_d = dec_c ? '0 : pcnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef COUNTDOWN_LOADER_ABORT_EN
        // Abort wins over everything, including a same-cycle push
        if (abort) begin
            state_d      = S_IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            pcnt_d       = '0;
            latch_d      = 1'b1;
            load_value_d = '0;
        end
`endif

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '{default: '0};
            pcnt_q       <= '0;
            latch_q      <= 1'b0;
            load_value_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            pcnt_q       <= pcnt_d;
            latch_q      <= latch_d;
            load_value_q <= load_value_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // dec must see the live zero input so it never fires on an expired count
    assign dec        = dec_c;
    assign req_ready  = !full_c;
    assign latch      = latch_q;
    assign load_value = load_value_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_countdown_loader.sv
// Testbench for countdown_loader: vector table, schedule-based reference model and corner sequences.
module tb_countdown_loader;

    localparam int P4    = 4;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // PRESCALE=4 instance
    logic       req_valid, req_ready, latch, dec, zero, busy, done;
    logic [3:0] req_value, load_value;
    // PRESCALE=1 instance
    logic       r1_valid, r1_ready, r1_latch, r1_dec, r1_zero, r1_busy, r1_done;
    logic [3:0] r1_value, r1_load_value;
`ifdef COUNTDOWN_LOADER_ABORT_EN
    logic       abort4, abort1;
`endif

    countdown_loader #(.PRESCALE(4), .FIFO_DEPTH(4)) dut4 (
        .clock(clock), .reset(reset),
`ifdef COUNTDOWN_LOADER_ABORT_EN
        .abort(abort4),
`endif
        .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
        .latch(latch), .load_value(load_value), .dec(dec), .zero(zero),
        .busy(busy), .done(done)
    );

    countdown_loader #(.PRESCALE(1), .FIFO_DEPTH(4)) dut1 (
        .clock(clock), .reset(reset),
`ifdef COUNTDOWN_LOADER_ABORT_EN
        .abort(abort1),
`endif
        .req_valid(r1_valid), .req_value(r1_value), .req_ready(r1_ready),
        .latch(r1_latch), .load_value(r1_load_value), .dec(r1_dec), .zero(r1_zero),
        .busy(r1_busy), .done(r1_done)
    );

    // Behavioural 4-bit counter stages (not touched by reset)
    logic [3:0] cnt4_q, cnt1_q;
    always_ff @(posedge clock) begin
        if (latch) cnt4_q <= load_value;
        else if (dec && cnt4_q != 4'd0) cnt4_q <= cnt4_q - 4'd1;
        if (r1_latch) cnt1_q <= r1_load_value;
        else if (r1_dec && cnt1_q != 4'd0) cnt1_q <= cnt1_q - 4'd1;
    end
    assign zero    = (cnt4_q == 4'd0);
    assign r1_zero = (cnt1_q == 4'd0);

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Reference model: one record per accepted request with its scheduled cycles
    int ja[$];
    int jl[$];
    int jd[$];
    int jn[$];
    int last_done;
    int base_lv;

    task automatic model_reset(input int lv);
        ja.delete(); jl.delete(); jd.delete(); jn.delete();
        last_done = -1000;
        base_lv   = lv;
        cyc       = 0;
    endtask

    // Drive one cycle on dut4, check every output against the model, record acceptance
    task automatic step(input logic v, input logic [3:0] val, output logic acc);
        int occ, e_lv, best, d, L, D;
        logic e_lat, e_dec, e_dn, e_bsy, e_rdy;
        req_valid = v;
        req_value = val;
        @(negedge clock);
        occ = 0; e_lat = 0; e_lv = base_lv; best = -1; e_dec = 0; e_dn = 0; e_bsy = 0;
        for (int i = 0; i < ja.size(); i++) begin
            if (ja[i] < cyc) occ++;
            if (jl[i] < cyc) occ--;
            if (jl[i] == cyc) e_lat = 1;
            if (jl[i] <= cyc && jl[i] > best) begin best = jl[i]; e_lv = jn[i]; end
            d = cyc - jl[i];
            if (d >= P4 && d <= jn[i] * P4 && (d % P4) == 0) e_dec = 1;
            if (jd[i] == cyc) e_dn = 1;
            if (jl[i] <= cyc && cyc <= jd[i]) e_bsy = 1;
        end
        e_rdy = (occ < DEPTH);
        chk("req_ready",  int'(req_ready),  int'(e_rdy));
        chk("latch",      int'(latch),      int'(e_lat));
        chk("load_value", int'(load_value), e_lv);
        chk("dec",        int'(dec),        int'(e_dec));
        chk("done",       int'(done),       int'(e_dn));
        chk("busy",       int'(busy),       int'(e_bsy));
        acc = v && e_rdy;
        if (acc) begin
            L = (cyc + 2 > last_done + 2) ? cyc + 2 : last_done + 2;
            D = L + int'(val) * P4 + 2;
            ja.push_back(cyc); jl.push_back(L); jd.push_back(D); jn.push_back(int'(val));
            last_done = D;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        logic a;
        for (int t = 0; t < 500 && last_done >= cyc; t++) step(1'b0, 4'd0, a);
    endtask

    typedef struct {
        int v; int val; int la; int lv; int de; int dn; int bs; int rd;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input int v, input int val, input int la, input int lv,
                           input int de, input int dn, input int bs, input int rd);
        vec_t r;
        r.v = v; r.val = val; r.la = la; r.lv = lv; r.de = de; r.dn = dn; r.bs = bs; r.rd = rd;
        tbl.push_back(r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic a;
        int   idx;
        int   bp[6];
        int   lat_c, dn_c, ndec, first_dec, last_dec;

        reset = 1'b1;
        req_valid = 1'b0; req_value = 4'd0;
        r1_valid = 1'b0;  r1_value = 4'd0;
`ifdef COUNTDOWN_LOADER_ABORT_EN
        abort4 = 1'b0; abort1 = 1'b0;
`endif
        @(posedge clock);
        #1;
        chk("rst_latch",      int'(latch),      0);
        chk("rst_load_value", int'(load_value), 0);
        chk("rst_dec",        int'(dec),        0);
        chk("rst_done",       int'(done),       0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_req_ready",  int'(req_ready),  1);
        chk("rst1_req_ready", int'(r1_ready),   1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single countdown of 2 at PRESCALE=4, cycle by cycle from acceptance
        //      v val la lv de dn bs rd
        add_vec(1, 2, 0, 0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 0, 1, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 1, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 1, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 1, 1);
        add_vec(0, 0, 0, 2, 0, 1, 1, 1);
        add_vec(0, 0, 0, 2, 0, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].v[0];
            req_value = 4'(tbl[i].val);
            @(negedge clock);
            chk($sformatf("tbl%0d.latch", i),      int'(latch),      tbl[i].la);
            chk($sformatf("tbl%0d.load_value", i), int'(load_value), tbl[i].lv);
            chk($sformatf("tbl%0d.dec", i),        int'(dec),        tbl[i].de);
            chk($sformatf("tbl%0d.done", i),       int'(done),       tbl[i].dn);
            chk($sformatf("tbl%0d.busy", i),       int'(busy),       tbl[i].bs);
            chk($sformatf("tbl%0d.req_ready", i),  int'(req_ready),  tbl[i].rd);
            @(posedge clock);
            #1;
        end

        // Zero value: latch, no dec, done 4 cycles after acceptance
        model_reset(2);
        step(1'b1, 4'd0, a);
        chk("zero_accept", int'(a), 1);
        drain();
        step(1'b0, 4'd0, a);

        // Back-pressure: a running countdown, then a burst that overfills the FIFO
        bp = '{2, 3, 1, 2, 4, 1};
        for (int i = 0; i < 6; i++) begin
            a = 1'b0;
            for (int t = 0; t < 100 && !a; t++) step(1'b1, 4'(bp[i]), a);
            chk($sformatf("bp_accept%0d", i), int'(a), 1);
        end
        drain();

        // Randomized traffic
        for (int t = 0; t < 500; t++) begin
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), a);
        end
        drain();

        // Reset in the middle of a RUN with two entries queued
        step(1'b1, 4'd9, a);
        idx = jl.size() - 1;
        step(1'b1, 4'd5, a);
        step(1'b1, 4'd7, a);
        for (int t = 0; t < 50 && cyc < jl[idx] + 4; t++) step(1'b0, 4'd0, a);
        chk("pre_rst_dec", int'(dec), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_latch",      int'(latch),      0);
        chk("arst_load_value", int'(load_value), 0);
        chk("arst_dec",        int'(dec),        0);
        chk("arst_done",       int'(done),       0);
        chk("arst_busy",       int'(busy),       0);
        chk("arst_req_ready",  int'(req_ready),  1);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_reset(0);
        for (int t = 0; t < 3; t++) step(1'b0, 4'd0, a);
        step(1'b1, 4'd1, a);
        drain();
        for (int t = 0; t < 4; t++) step(1'b0, 4'd0, a);

`ifdef COUNTDOWN_LOADER_ABORT_EN
        // Abort mid-RUN with queued entries and a simultaneous push
        step(1'b1, 4'd6, a);
        idx = jl.size() - 1;
        step(1'b1, 4'd8, a);
        step(1'b1, 4'd4, a);
        for (int t = 0; t < 50 && cyc < jl[idx] + 5; t++) step(1'b0, 4'd0, a);
        abort4    = 1'b1;
        req_valid = 1'b1;
        req_value = 4'd9;
        @(posedge clock);
        #1;
        abort4    = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        chk("abort_latch",      int'(latch),      1);
        chk("abort_load_value", int'(load_value), 0);
        chk("abort_done",       int'(done),       0);
        chk("abort_busy",       int'(busy),       0);
        chk("abort_req_ready",  int'(req_ready),  1);
        @(posedge clock);
        #1;
        model_reset(0);
        for (int t = 0; t < 15; t++) step(1'b0, 4'd0, a);
        step(1'b1, 4'd1, a);
        drain();
`endif

        // PRESCALE=1: push 15, dec on 15 consecutive cycles, done 19 cycles after acceptance
        lat_c = -1; dn_c = -1; ndec = 0; first_dec = -1; last_dec = -1;
        r1_valid = 1'b1;
        r1_value = 4'd15;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (c == 0) chk("p1_req_ready", int'(r1_ready), 1);
            if (r1_latch) lat_c = c;
            if (r1_dec) begin
                ndec++;
                if (first_dec < 0) first_dec = c;
                last_dec = c;
            end
            if (r1_done) dn_c = c;
            @(posedge clock);
            #1;
            r1_valid = 1'b0;
        end
        chk("p1_latch_cycle",  lat_c, 2);
        chk("p1_load_value",   int'(r1_load_value), 15);
        chk("p1_dec_count",    ndec, 15);
        chk("p1_first_dec",    first_dec, 3);
        chk("p1_last_dec",     last_dec, 17);
        chk("p1_done_cycle",   dn_c, 19);
        chk("p1_busy_after",   int'(r1_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
